// File: rtl/tug_pkg.sv
// Shared FSM state encoding and player identifiers for the tug-of-war playfield.
package tug_pkg;

   typedef enum logic [1:0] {
      PLAY       = 2'd0,
      WIN_HOLD   = 2'd1,
      MATCH_OVER = 2'd2
   } state_e;

   localparam logic LEFT  = 1'b1;
   localparam logic RIGHT = 1'b0;

endpackage

// File: rtl/tug_field_n_press_edge.sv
// Rising-edge press detector; prev resets high so a button held through reset never counts.
module press_edge (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic press
);

   logic prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev_q <= 1'b1;
      else      prev_q <= in;
   end

   assign press = in & ~prev_q;

endmodule

// File: rtl/tug_field_n.sv
// N-light tug-of-war field: light moves toward the presser, edge press scores,
// winning edge is held then recentred, first to MATCH_POINTS ends the match.
module tug_field_n
   import tug_pkg::*;
#(
   parameter  int unsigned NUM_LIGHTS   = 9,
   parameter  int unsigned HOLD_CYCLES  = 4,
   parameter  int unsigned MATCH_POINTS = 3,
   localparam int unsigned SCORE_W      = $clog2(MATCH_POINTS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  L,
   input  logic                  R,
   output logic [NUM_LIGHTS-1:0] leds,
   output logic                  win_left,
   output logic                  win_right,
   output logic [SCORE_W-1:0]    score_left,
   output logic [SCORE_W-1:0]    score_right,
   output logic                  match_over,
   output logic                  match_winner
);

   localparam int unsigned POS_W  = $clog2(NUM_LIGHTS);
   localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [POS_W-1:0]      POS_MAX   = POS_W'(NUM_LIGHTS - 1);
   localparam logic [POS_W-1:0]      POS_C     = POS_W'((NUM_LIGHTS - 1) / 2);
   localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [SCORE_W-1:0]    SCORE_MAX = SCORE_W'(MATCH_POINTS);
   localparam logic [NUM_LIGHTS-1:0] LEDS_RST  = NUM_LIGHTS'(1) << POS_C;

   logic press_l, press_r;

   press_edge u_edge_l (.clk(clk), .rst(rst), .in(L), .press(press_l));
   press_edge u_edge_r (.clk(clk), .rst(rst), .in(R), .press(press_r));

   state_e                  state_q, state_d;
   logic [POS_W-1:0]        pos_q, pos_d;
   logic [HOLD_W-1:0]       hold_q, hold_d;
   logic [SCORE_W-1:0]      score_l_q, score_l_d;
   logic [SCORE_W-1:0]      score_r_q, score_r_d;
   logic                    win_l_q, win_l_d;
   logic                    win_r_q, win_r_d;
   logic                    winner_q, winner_d;
   logic                    over_q, over_d;
   logic [NUM_LIGHTS-1:0]   leds_q, leds_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= PLAY;
         pos_q     <= POS_C;
         hold_q    <= '0;
         score_l_q <= '0;
         score_r_q <= '0;
         win_l_q   <= 1'b0;
         win_r_q   <= 1'b0;
         winner_q  <= 1'b0;
         over_q    <= 1'b0;
         leds_q    <= LEDS_RST;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         hold_q    <= hold_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         win_l_q   <= win_l_d;
         win_r_q   <= win_r_d;
         winner_q  <= winner_d;
         over_q    <= over_d;
         leds_q    <= leds_d;
      end
   end

   // Next state; simultaneous presses cancel and the edge light stays lit on a score.
   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      hold_d    = hold_q;
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      win_l_d   = 1'b0;
      win_r_d   = 1'b0;
      winner_d  = winner_q;

      unique case (state_q)
         PLAY: begin
            if (press_l && !press_r) begin
               if (pos_q == POS_MAX) begin
                  score_l_d = score_l_q + SCORE_W'(1);
                  win_l_d   = 1'b1;
                  hold_d    = '0;
                  if (score_l_d == SCORE_MAX) begin
                     state_d  = MATCH_OVER;
                     winner_d = LEFT;
                  end else begin
                     state_d  = WIN_HOLD;
                  end
               end else begin
                  pos_d = pos_q + POS_W'(1);
               end
            end else if (press_r && !press_l) begin
               if (pos_q == '0) begin
                  score_r_d = score_r_q + SCORE_W'(1);
                  win_r_d   = 1'b1;
                  hold_d    = '0;
                  if (score_r_d == SCORE_MAX) begin
                     state_d  = MATCH_OVER;
                     winner_d = RIGHT;
                  end else begin
                     state_d  = WIN_HOLD;
                  end
               end else begin
                  pos_d = pos_q - POS_W'(1);
               end
            end
         end
         WIN_HOLD: begin
            if (hold_q == HOLD_LAST) begin
               pos_d   = POS_C;
               hold_d  = '0;
               state_d = PLAY;
            end else begin
               hold_d  = hold_q + HOLD_W'(1);
            end
         end
         MATCH_OVER: begin
         end
         default: state_d = PLAY;
      endcase

      over_d = (state_d == MATCH_OVER);
      leds_d = over_d ? '1 : (NUM_LIGHTS'(1) << pos_d);
   end

   assign leds         = leds_q;
   assign win_left     = win_l_q;
   assign win_right    = win_r_q;
   assign score_left   = score_l_q;
   assign score_right  = score_r_q;
   assign match_over   = over_q;
   assign match_winner = winner_q;

endmodule

// File: doc/tug_field_n.md
Name: tug_field_n

Overview:
- Parametrised successor to the fixed 9-light tug-of-war playfield.
- One lit LED on an N-light field moves one step toward the player who presses. A press with the light already on that player's edge scores a point.
- Adds internal press edge detection, win hold/auto-recentre, per-player score counters and match-over detection.
- Sits between the synchronised KEY inputs and the LEDR/HEX drivers in the game top level.

Parameters:
- NUM_LIGHTS, 9: field width; must be odd and >= 3. Centre index C = (NUM_LIGHTS-1)/2.
- HOLD_CYCLES, 4: cycles the winning edge light is held before recentring; must be >= 1.
- MATCH_POINTS, 3: points needed to win the match; must be >= 1. Derived localparam SCORE_W = $clog2(MATCH_POINTS+1).

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- rst, input, 1: asynchronous, active-low reset.
- L, input, 1: left player button, level, already synchronised.
- R, input, 1: right player button, level, already synchronised.
- leds, output, NUM_LIGHTS: field LEDs; index 0 = rightmost, index NUM_LIGHTS-1 = leftmost.
- win_left, output, 1: one-cycle pulse when left scores.
- win_right, output, 1: one-cycle pulse when right scores.
- score_left, output, SCORE_W: left points.
- score_right, output, SCORE_W: right points.
- match_over, output, 1: high once either score reaches MATCH_POINTS.
- match_winner, output, 1: 1 = left won the match, 0 = right; valid only while match_over is high.

Behaviour:
- Reset (rst low, async): state=PLAY, pos=C, leds=one-hot C. L_prev=1 and R_prev=1, so a button held through reset is not counted. Scores=0, hold counter=0, win pulses=0, match_over=0, match_winner=0.
- Press detection: pressL = L & ~L_prev, pressR = R & ~R_prev. L_prev and R_prev are registered every cycle in every state. A held button yields exactly one press.
- pressL and pressR in the same cycle: no movement and no score, in every state.
- PLAY state:
  - pressL only, pos < N-1: pos += 1.
  - pressR only, pos > 0: pos -= 1.
  - pressL only, pos == N-1: left scores.
  - pressR only, pos == 0: right scores.
  - leds = one-hot pos.
  - Latency: a press sampled at posedge k shows on leds after posedge k.
- Score event (same posedge):
  - Win pulse asserted for exactly one cycle; scorer's count incremented; pos unchanged (edge stays lit).
  - If the new score == MATCH_POINTS: go to MATCH_OVER and set match_winner. Otherwise go to WIN_HOLD with hold counter = 0.
- WIN_HOLD state:
  - Presses ignored; leds hold the winning edge light.
  - Counter increments each cycle. When counter == HOLD_CYCLES-1: pos=C, state=PLAY.
  - The first press that can move the light is sampled on the first cycle after returning to PLAY.
- MATCH_OVER state:
  - leds = all ones; match_over = 1; presses ignored; scores frozen.
  - Leave only via reset.
- Scores never exceed MATCH_POINTS; no wrap.
- Reset mid-hold or mid-match: immediately returns all outputs to their reset values.

Decomposition:
- Package tug_pkg: state enum {PLAY, WIN_HOLD, MATCH_OVER} and the player-id constants LEFT=1, RIGHT=0.
- Sub-module press_edge (clk, rst, in, press): holds the prev register (reset to 1) and produces the one-cycle press. Instantiated twice, for L and R.
- The remainder is a single FSM with the pos, hold and score registers.

Test Plan (N=9, HOLD=4, MATCH=3):
- Reset release with L and R low → leds=9'b000010000, scores 0/0, match_over=0. Holding L high through reset then releasing reset → no movement.
- Hold R high for 10 cycles → exactly one step, leds=9'b000001000. Release R and give 3 single R pulses → leds=9'b000000001 (pos 0).
- From pos 0, R pulse → win_right high for exactly 1 cycle, score_right=1, leds=9'b000000001 held for 4 cycles. Presses during the hold have no effect. Next cycle leds=9'b000010000.
- L and R rising in the same cycle at pos 4 → leds unchanged, no pulse. Repeat at pos 8 → no score.
- Left wins 3 rounds (5 L pulses per round, separated by holds) → third win: score_left=3, match_over=1, match_winner=1, leds=9'h1FF. Further presses change nothing.
- Assert rst low mid-WIN_HOLD, asynchronously between clock edges → outputs return to reset values before the next posedge. Scores return to 0/0.
